hazard_ctrl: RTL and testbench

//  Pipeline stall/flush controller; drives the IF/ID register's write-enable and flush

---
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for load-use, branch, memory-wait and multiply hazards.
// Defining HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             mul_start_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             if_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int MW = $clog2(MUL_LAT + 1);
    localparam logic [MW-1:0] MCNT_INIT = MW'(MUL_LAT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MUL_BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [MW-1:0] r_mcnt, w_mcnt_nxt;
    logic          w_mem_stall, w_lu, w_hold, w_lu_act, w_br_act;

    assign w_mem_stall = mem_req_i && !mem_ack_i;
    assign w_lu = idex_memread_i && (idex_rt_i != '0) &&
                  (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= RUN;
            r_mcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        w_hold      = 1'b1;
        w_lu_act    = 1'b0;
        w_br_act    = 1'b0;
        case (r_state)
            RUN: begin
                w_hold   = w_mem_stall || mul_start_i;
                w_lu_act = !w_hold && w_lu;
                w_br_act = !w_hold && !w_lu && branch_taken_i;
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                end else if (mul_start_i && MUL_LAT > 1) begin
                    w_state_nxt = MUL_BUSY;
                    w_mcnt_nxt  = MCNT_INIT;
                end
            end
            MEM_WAIT: w_state_nxt = mem_ack_i ? RUN : MEM_WAIT;
            MUL_BUSY: begin
                w_mcnt_nxt  = r_mcnt - MW'(1);
                w_state_nxt = (r_mcnt == MW'(1)) ? RUN : MUL_BUSY;
            end
            default: w_state_nxt = RUN;
        endcase
        // reset overrides everything: no fetch, flush IF/ID, bubble ID/EX
        pc_write_o    = rst_i && !w_hold && !w_lu_act;
        ifid_write_o  = rst_i && !w_hold && !w_lu_act;
        if_flush_o    = !rst_i || w_br_act;
        idex_bubble_o = !rst_i || w_lu_act;
        pipe_hold_o   = rst_i && w_hold;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (if_flush_o && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench driving a MUL_LAT=4 and a MUL_LAT=1 controller from shared inputs.
module tb_hazard_ctrl;
    localparam logic [4:0] O_RUN = 5'b11000, O_HOLD = 5'b00001, O_LU = 5'b00010,
                           O_BR = 5'b11100, O_RST = 5'b00110;
    localparam logic [4:0] R0 = 5'd0, R8 = 5'd8, R9 = 5'd9, R3 = 5'd3;
    localparam logic H = 1'b1, L = 1'b0;

    typedef struct packed {
        logic       rst, memread;
        logic [4:0] irt, rs, rt;
        logic       br, req, ack, mul;
    } stim_t;

    logic clk_i = 1'b0, rst_i = 1'b1, memread = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0, mul = 1'b0;
    logic [4:0] irt = '0, rs = '0, rt = '0;
    logic [4:0] o4, o1;
    logic [31:0] stall4, flush4, stall1, flush1;
    logic [9:0] sb[$];
    int n_pass = 0, n_chk = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(memread), .idex_rt_i(irt),
        .ifid_rs_i(rs), .ifid_rt_i(rt), .branch_taken_i(br), .mem_req_i(req),
        .mem_ack_i(ack), .mul_start_i(mul), .pc_write_o(o4[4]), .ifid_write_o(o4[3]),
        .if_flush_o(o4[2]), .idex_bubble_o(o4[1]), .pipe_hold_o(o4[0]),
        .stall_cnt_o(stall4), .flush_cnt_o(flush4));

    hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(memread), .idex_rt_i(irt),
        .ifid_rs_i(rs), .ifid_rt_i(rt), .branch_taken_i(br), .mem_req_i(req),
        .mem_ack_i(ack), .mul_start_i(mul), .pc_write_o(o1[4]), .ifid_write_o(o1[3]),
        .if_flush_o(o1[2]), .idex_bubble_o(o1[1]), .pipe_hold_o(o1[0]),
        .stall_cnt_o(stall1), .flush_cnt_o(flush1));

`ifdef HAZARD_PERF_EN
    logic [3:0] stall_c4, flush_c4;
    logic [4:0] oc4;
    hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut_c4 (
        .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(memread), .idex_rt_i(irt),
        .ifid_rs_i(rs), .ifid_rt_i(rt), .branch_taken_i(br), .mem_req_i(req),
        .mem_ack_i(ack), .mul_start_i(mul), .pc_write_o(oc4[4]), .ifid_write_o(oc4[3]),
        .if_flush_o(oc4[2]), .idex_bubble_o(oc4[1]), .pipe_hold_o(oc4[0]),
        .stall_cnt_o(stall_c4), .flush_cnt_o(flush_c4));
`endif

    function automatic stim_t mk(input logic r, m, input logic [4:0] a, b, c,
                                 input logic d, q, k, u);
        mk = {r, m, a, b, c, d, q, k, u};
    endfunction

    task automatic apply(input stim_t s);
        rst_i = s.rst; memread = s.memread; irt = s.irt; rs = s.rs; rt = s.rt;
        br = s.br; req = s.req; ack = s.ack; mul = s.mul;
    endtask

    task automatic test_reset();
        stim_t s[3];
        logic [9:0] e[3];
        logic [9:0] want;
        s = '{mk(L,L,R0,R0,R0,L,L,L,L), mk(L,H,R8,R8,R0,H,H,L,H), mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_RST,O_RST}, {O_RST,O_RST}, {O_RUN,O_RUN}};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL reset[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
            if (i == 0) begin
                n_chk++;
                if ({stall4, flush4} !== 64'd0) $display("FAIL reset_cnt got %0d/%0d want 0/0", stall4, flush4);
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[5];
        logic [9:0] e[5];
        logic [9:0] want;
        s = '{mk(H,H,R8,R8,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,H,R0,R0,R0,L,L,L,L),
              mk(H,H,R8,R3,R8,L,L,L,L), mk(H,L,R8,R8,R8,L,L,L,L)};
        e = '{{O_LU,O_LU}, {O_RUN,O_RUN}, {O_RUN,O_RUN}, {O_LU,O_LU}, {O_RUN,O_RUN}};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL load_use[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        stim_t s[3];
        logic [9:0] e[3];
        logic [9:0] want;
        s = '{mk(H,L,R0,R0,R0,H,L,L,L), mk(H,H,R9,R3,R9,H,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_BR,O_BR}, {O_LU,O_LU}, {O_RUN,O_RUN}};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL branch[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

    task automatic test_mem();
        stim_t s[7];
        logic [9:0] e[7];
        logic [9:0] want;
        s = '{mk(H,L,R0,R0,R0,H,H,L,L), mk(H,L,R0,R0,R0,L,H,L,L), mk(H,H,R8,R8,R0,L,H,L,L),
              mk(H,L,R0,R0,R0,L,H,H,L), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,H,H,L),
              mk(H,L,R0,R0,R0,H,H,H,L)};
        e = '{{O_HOLD,O_HOLD}, {O_HOLD,O_HOLD}, {O_HOLD,O_HOLD}, {O_HOLD,O_HOLD},
              {O_RUN,O_RUN}, {O_RUN,O_RUN}, {O_BR,O_BR}};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL mem[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

    task automatic test_mul();
        stim_t s[5];
        logic [9:0] e[5];
        logic [9:0] want;
        s = '{mk(H,L,R0,R0,R0,L,L,L,H), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,H,R8,R8,R0,L,L,L,L),
              mk(H,L,R0,R0,R0,H,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_HOLD,O_HOLD}, {O_HOLD,O_RUN}, {O_HOLD,O_LU}, {O_HOLD,O_BR}, {O_RUN,O_RUN}};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL mul[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

    task automatic test_mul_reset();
        stim_t s[8];
        logic [9:0] e[8];
        logic [9:0] want;
        s = '{mk(H,L,R0,R0,R0,L,L,L,H), mk(L,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L),
              mk(H,L,R0,R0,R0,L,L,L,H), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L),
              mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_HOLD,O_HOLD}, {O_RST,O_RST}, {O_RUN,O_RUN}, {O_HOLD,O_HOLD},
              {O_HOLD,O_RUN}, {O_HOLD,O_RUN}, {O_HOLD,O_RUN}, {O_RUN,O_RUN}};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL mul_reset[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

    task automatic test_mem_mul();
        stim_t s[7];
        logic [9:0] e[7];
        logic [9:0] want;
        s = '{mk(H,L,R0,R0,R0,L,H,L,H), mk(H,L,R0,R0,R0,L,H,H,H), mk(H,L,R0,R0,R0,L,L,L,H),
              mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L),
              mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_HOLD,O_HOLD}, {O_HOLD,O_HOLD}, {O_HOLD,O_HOLD}, {O_HOLD,O_RUN},
              {O_HOLD,O_RUN}, {O_HOLD,O_RUN}, {O_RUN,O_RUN}};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL mem_mul[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        stim_t s[9];
        logic [9:0] e[9];
        logic [9:0] want;
        s = '{mk(L,L,R0,R0,R0,L,L,L,L), mk(H,H,R8,R8,R0,L,L,L,L), mk(H,L,R0,R0,R0,H,L,L,L),
              mk(H,H,R9,R3,R9,H,L,L,L), mk(H,L,R0,R0,R0,L,L,L,H), mk(H,L,R0,R0,R0,L,L,L,L),
              mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L), mk(H,L,R0,R0,R0,L,L,L,L)};
        e = '{{O_RST,O_RST}, {O_LU,O_LU}, {O_BR,O_BR}, {O_LU,O_LU}, {O_HOLD,O_HOLD},
              {O_HOLD,O_RUN}, {O_HOLD,O_RUN}, {O_HOLD,O_RUN}, {O_RUN,O_RUN}};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_i); #1; apply(s[i]); sb.push_back(e[i]);
            @(negedge clk_i); want = sb.pop_front(); n_chk++;
            if ({o4, o1} !== want) $display("FAIL perf[%0d] got %b want %b", i, {o4, o1}, want);
            else n_pass++;
        end
        @(posedge clk_i); #1; n_chk++;
        if (stall4 !== 32'd6 || flush4 !== 32'd1)
            $display("FAIL perf_cnt got %0d/%0d want 6/1", stall4, flush4);
        else n_pass++;
        apply(mk(H,L,R0,R0,R0,L,H,L,L));
        for (int i = 0; i < 20; i++) @(posedge clk_i);
        #1; apply(mk(H,L,R0,R0,R0,L,H,H,L));
        @(posedge clk_i); #1; apply(mk(H,L,R0,R0,R0,L,L,L,L)); n_chk++;
        if (stall_c4 !== 4'd15) $display("FAIL perf_sat got %0d want 15", stall_c4);
        else n_pass++;
        n_chk++;
        if (stall4 !== 32'd27) $display("FAIL perf_wide got %0d want 27", stall4);
        else n_pass++;
    endtask
`else
    task automatic test_perf();
        @(negedge clk_i); n_chk++;
        if ({stall4, flush4, stall1, flush1} !== 128'd0)
            $display("FAIL perf_off got %0d/%0d want 0/0", stall4, flush4);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem();
        test_mul();
        test_mul_reset();
        test_mem_mul();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
